// File: rtl/core_mdu.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply and restoring divide.
// One operation in flight; the caller holds off until the single-cycle done pulse.
module core_mdu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned    CntW    = $clog2(XLEN) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN);
  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StSpecial, StRun, StDone} state_e;

  state_e            r_state;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_mag_a;
  logic [XLEN-1:0]   r_mag_b;
  logic              r_sa;
  logic              r_sb;
  logic              r_div0;
  logic [CntW-1:0]   r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_in_sa;
  logic              w_in_sb;
  logic [XLEN-1:0]   w_in_mag_a;
  logic [XLEN-1:0]   w_in_mag_b;
  logic              w_in_div0;
  logic              w_in_ovf;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_acc_next;
  logic [XLEN:0]     w_div_shift;
  logic [XLEN:0]     w_div_diff;
  logic              w_div_ge;
  logic              w_neg;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;
  logic [XLEN-1:0]   w_special;

  // Operand signedness: MULH/DIV/REM sign both, MULHSU signs only rs1.
  always_comb begin
    w_in_sa = 1'b0;
    w_in_sb = 1'b0;
    case (i_op)
      3'b001, 3'b100, 3'b110: begin
        w_in_sa = i_a[XLEN-1];
        w_in_sb = i_b[XLEN-1];
      end
      3'b010:  w_in_sa = i_a[XLEN-1];
      default: ;
    endcase
  end

  assign w_in_mag_a = w_in_sa ? -i_a : i_a;
  assign w_in_mag_b = w_in_sb ? -i_b : i_b;
  assign w_in_div0  = i_op[2] & (i_b == '0);
  assign w_in_ovf   = i_op[2] & ~i_op[0] & (i_a == MinNeg) & (i_b == '1);

  // Multiply step: add multiplicand into the high half if the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
  assign w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide step: the dividend shifts out of r_quo MSB first while quotient
  // bits shift in at the bottom. The sign of the trial difference decides.
  assign w_div_shift = {r_rem, r_quo[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_mag_b};
  assign w_div_ge    = ~w_div_diff[XLEN];

  assign w_neg  = r_sa ^ r_sb;
  assign w_prod = w_neg ? -r_acc : r_acc;
  assign w_quo  = w_neg ? -r_quo : r_quo;
  assign w_rem  = r_sa ? -r_rem : r_rem;

  always_comb begin
    w_final = '0;
    case (r_op)
      3'b000:                 w_final = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = w_quo;
      default:                w_final = w_rem;
    endcase
  end

  // op[1] separates REM/REMU from DIV/DIVU among the divide ops.
  assign w_special = r_div0 ? (r_op[1] ? r_a : '1) : (r_op[1] ? '0 : r_a);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_op     <= '0;
      r_a      <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_div0   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_op    <= i_op;
            r_a     <= i_a;
            r_mag_a <= w_in_mag_a;
            r_mag_b <= w_in_mag_b;
            r_sa    <= w_in_sa;
            r_sb    <= w_in_sb;
            r_div0  <= w_in_div0;
            r_cnt   <= '0;
            r_acc   <= {{XLEN{1'b0}}, w_in_mag_b};
            r_rem   <= '0;
            r_quo   <= w_in_mag_a;
            r_busy  <= 1'b1;
            r_state <= (w_in_div0 || w_in_ovf) ? StSpecial : StRun;
          end
        end
        StSpecial: begin
          r_result <= w_special;
          r_done   <= 1'b1;
          r_state  <= StDone;
        end
        StRun: begin
          // XLEN iterating edges, then one edge applying the sign fix.
          if (r_cnt == CntLast) begin
            r_result <= w_final;
            r_done   <= 1'b1;
            r_state  <= StDone;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
            if (r_op[2]) begin
              r_rem <= w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
              r_quo <= {r_quo[XLEN-2:0], w_div_ge};
            end else begin
              r_acc <= w_acc_next;
            end
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_core_mdu.sv
// Bench for core_mdu: 32-bit and 8-bit instances, directed vector table,
// protocol/reset sequences and random ops against an arithmetic reference model.
module tb_core_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start32 = 1'b0, start8 = 1'b0;
  logic [2:0]  op32 = '0, op8 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy32, done32, busy8, done8;
  logic [31:0] res32;
  logic [7:0]  res8;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  core_mdu #(.XLEN(32)) u_dut32 (
    .clk(clk), .reset(reset), .i_start(start32), .i_op(op32), .i_a(a32), .i_b(b32),
    .o_busy(busy32), .o_done(done32), .o_result(res32)
  );

  core_mdu #(.XLEN(8)) u_dut8 (
    .clk(clk), .reset(reset), .i_start(start8), .i_op(op8), .i_a(a8), .i_b(b8),
    .o_busy(busy8), .o_done(done8), .o_result(res8)
  );

  typedef struct {
    string       name;
    bit          n8;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, bit n8, logic [2:0] op, logic [31:0] a,
                              logic [31:0] b, logic [31:0] exp, int lat);
    vec_t v;
    v.name = nm; v.n8 = n8; v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic longint sext(input longint unsigned v, input int w);
    if (v[w-1]) return longint'(v) - (longint'(1) << w);
    return longint'(v);
  endfunction

  // Reference: RISC-V M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a_in,
                                          input logic [31:0] b_in, input int w);
    longint unsigned mask = (longint'(1) << w) - 1;
    longint unsigned ua = longint'(a_in) & mask;
    longint unsigned ub = longint'(b_in) & mask;
    longint sa = sext(ua, w);
    longint sb = sext(ub, w);
    longint unsigned p;
    longint unsigned r;
    case (op)
      3'd0: begin p = ua * ub; r = p & mask; end
      3'd1: begin p = longint'(sa * sb); r = (p >> w) & mask; end
      3'd2: begin p = longint'(sa * longint'(ub)); r = (p >> w) & mask; end
      3'd3: begin p = ua * ub; r = (p >> w) & mask; end
      3'd4: begin
        if (ub == 0) r = mask;
        else if (sa == -(longint'(1) << (w - 1)) && sb == -1) r = ua;
        else r = longint'(sa / sb) & mask;
      end
      3'd5: r = (ub == 0) ? mask : (ua / ub);
      3'd6: begin
        if (ub == 0) r = ua;
        else if (sa == -(longint'(1) << (w - 1)) && sb == -1) r = 0;
        else r = longint'(sa % sb) & mask;
      end
      default: r = (ub == 0) ? ua : (ua % ub);
    endcase
    return r[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a_in,
                                 input logic [31:0] b_in, input int w);
    longint unsigned mask = (longint'(1) << w) - 1;
    longint unsigned ua = longint'(a_in) & mask;
    longint unsigned ub = longint'(b_in) & mask;
    if (op[2] && ub == 0) return 1;
    if (op[2] && !op[0] && ua == (longint'(1) << (w - 1)) && ub == mask) return 1;
    return w + 1;
  endfunction

  // Issue one op at E0, count edges until done, check the pulse and busy fall.
  task automatic do_op(input bit n8, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output int lat);
    if (n8) begin start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
    else begin start32 = 1'b1; op32 = op; a32 = a; b32 = b; end
    @(posedge clk); #1;
    start8 = 1'b0; start32 = 1'b0;
    chk("busy_rise", {31'b0, n8 ? busy8 : busy32}, 32'd1);
    lat = 0;
    while (!(n8 ? done8 : done32) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = n8 ? {24'b0, res8} : res32;
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, n8 ? done8 : done32}, 32'd0);
    chk("busy_fall", {31'b0, n8 ? busy8 : busy32}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int          lat;
    int          ndone;
    int          first;
    logic [31:0] first_res;

    vecs.push_back(mk("mul_7_m3",      0, 3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33));
    vecs.push_back(mk("mulh_min_min",  0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33));
    vecs.push_back(mk("mulhu_ones",    0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33));
    vecs.push_back(mk("mulhsu_ones",   0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33));
    vecs.push_back(mk("div_m7_2",      0, 3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33));
    vecs.push_back(mk("rem_m7_2",      0, 3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33));
    vecs.push_back(mk("divu_100_7",    0, 3'd5, 32'd100,      32'd7,        32'd14,       33));
    vecs.push_back(mk("remu_100_7",    0, 3'd7, 32'd100,      32'd7,        32'd2,        33));
    vecs.push_back(mk("rem_7_m2",      0, 3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        33));
    vecs.push_back(mk("div_by0",       0, 3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1));
    vecs.push_back(mk("divu_by0",      0, 3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1));
    vecs.push_back(mk("remu_by0",      0, 3'd7, 32'd5,        32'd0,        32'd5,        1));
    vecs.push_back(mk("rem_by0",       0, 3'd6, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 1));
    vecs.push_back(mk("div_ovf",       0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1));
    vecs.push_back(mk("rem_ovf",       0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1));
    vecs.push_back(mk("divu_no_ovf",   0, 3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33));
    vecs.push_back(mk("x8_divu_200_3", 1, 3'd5, 32'd200,      32'd3,        32'd66,       9));
    vecs.push_back(mk("x8_mulhu_ff",   1, 3'd3, 32'hFF,       32'hFF,       32'hFE,       9));
    vecs.push_back(mk("x8_div_ovf",    1, 3'd4, 32'h80,       32'hFF,       32'h80,       1));

    // Asynchronous reset values, checked before any clock edge.
    #3;
    chk("rst_busy", {31'b0, busy32}, 32'd0);
    chk("rst_done", {31'b0, done32}, 32'd0);
    chk("rst_result", res32, 32'd0);
    chk("rst_result8", {24'b0, res8}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_op(vecs[i].n8, vecs[i].op, vecs[i].a, vecs[i].b, r, lat);
      chk({vecs[i].name, "_result"}, r, vecs[i].exp);
      chk({vecs[i].name, "_latency"}, lat, vecs[i].lat);
    end

    // start pulsed during RUN and during the DONE cycle must be ignored.
    start32 = 1'b1; op32 = 3'd0; a32 = 32'd7; b32 = 32'hFFFFFFFD;
    @(posedge clk); #1;
    start32 = 1'b0;
    ndone = 0; first = -1; first_res = '0;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk); #1;
      if (done32) begin
        ndone++;
        if (first < 0) begin first = e; first_res = res32; end
      end
      start32 = (e == 4) || done32;
      op32 = 3'd4; a32 = 32'd5; b32 = 32'd0;
    end
    start32 = 1'b0;
    chk("ignored_start_done_count", ndone, 32'd1);
    chk("ignored_start_latency", first, 32'd33);
    chk("ignored_start_result", first_res, 32'hFFFFFFEB);
    chk("ignored_start_held", res32, 32'hFFFFFFEB);
    chk("ignored_start_idle", {31'b0, busy32}, 32'd0);

    // Reset asserted at iteration 10 discards the op immediately.
    start32 = 1'b1; op32 = 3'd5; a32 = 32'd100; b32 = 32'd7;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, busy32}, 32'd0);
    chk("midrst_done", {31'b0, done32}, 32'd0);
    chk("midrst_result", res32, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) ndone++;
    end
    chk("midrst_no_done", ndone, 32'd0);
    do_op(0, 3'd5, 32'd100, 32'd7, r, lat);
    chk("post_rst_divu", r, 32'd14);
    chk("post_rst_latency", lat, 32'd33);

    // Random ops, with corner operands injected now and then.
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op(0, rop, ra, rb, r, lat);
      chk($sformatf("rand32_%0d_op%0d_result", i, rop), r, ref_mdu(rop, ra, rb, 32));
      chk($sformatf("rand32_%0d_latency", i), lat, ref_lat(rop, ra, rb, 32));
    end

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra = 32'($urandom_range(0, 255));
      rb = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 7) == 0) begin ra = 32'h80; rb = 32'hFF; end
      do_op(1, rop, ra, rb, r, lat);
      chk($sformatf("rand8_%0d_op%0d_result", i, rop), r, ref_mdu(rop, ra, rb, 8));
      chk($sformatf("rand8_%0d_latency", i), lat, ref_lat(rop, ra, rb, 8));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
